// File: rtl/dc_tag_checker.sv
// Data-cache tag checker: fetches a line plus tag word over AXI for lookups,
// writes a line over AXI for fills, and returns one response per request.
module dc_tag_checker #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 512,
  parameter int unsigned TAG_S    = 64,
  parameter int unsigned ID_W     = 16,
  parameter int unsigned ID       = 1,
  parameter int unsigned INDEX_W  = 26,
  parameter int unsigned OFFSET_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [DATA_W-1:0]       req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_write_o,
  output logic                    rsp_hit_o,
  output logic                    rsp_dirty_o,
  output logic [DATA_W-1:0]       rsp_data_o,
  output logic [ID_W-1:0]         arid_o,
  output logic [ADDR_W-1:0]       araddr_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [ID_W-1:0]         rid_i,
  input  logic [DATA_W+TAG_S-1:0] rdata_i,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  output logic [ID_W-1:0]         awid_o,
  output logic [ADDR_W-1:0]       awaddr_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [ID_W-1:0]         wid_o,
  output logic [DATA_W-1:0]       wdata_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [ID_W-1:0]         bid_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o
);

  localparam int unsigned TAG_F_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned R_W     = DATA_W + TAG_S;
  localparam int unsigned V_BIT   = R_W - 1;
  localparam int unsigned D_BIT   = R_W - 2;
  localparam int unsigned TF_HI   = R_W - 3;
  localparam int unsigned TF_LO   = R_W - 2 - TAG_F_W;

  typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RSP} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:OFFSET_W]   addr_q;
  logic [DATA_W-1:0]          data_q;
  logic                       write_q, hit_q, dirty_q;
  logic [31:0]                hit_cnt_q, miss_cnt_q;
  logic                       req_ready_q, arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, rsp_valid_q;
  logic                       req_ready_d, arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d, rsp_valid_d;
  logic                       req_hs, r_hs, aw_pend, w_pend, tag_hit;

  // Next state plus next value of every handshake output, so all of them leave from flops
  always_comb begin
    state_d = state_q;
    req_hs  = req_valid_i & req_ready_q;
    r_hs    = rvalid_i & rready_q;
    aw_pend = awvalid_q & ~awready_i;
    w_pend  = wvalid_q & ~wready_i;
    tag_hit = rdata_i[V_BIT] & (rdata_i[TF_HI:TF_LO] == addr_q[ADDR_W-1 -: TAG_F_W]);
    case (state_q)
      IDLE:    if (req_hs) state_d = req_write_i ? AWW : AR;
      AR:      if (arready_i) state_d = R;
      R:       if (rvalid_i) state_d = RSP;
      AWW:     if (!aw_pend && !w_pend) state_d = B;
      B:       if (bvalid_i) state_d = RSP;
      RSP:     if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    arvalid_d   = (state_d == AR);
    rready_d    = (state_d == R);
    bready_d    = (state_d == B);
    rsp_valid_d = (state_d == RSP);
    awvalid_d   = ((state_q == IDLE) && (state_d == AWW)) || ((state_q == AWW) && aw_pend);
    wvalid_d    = ((state_q == IDLE) && (state_d == AWW)) || ((state_q == AWW) && w_pend);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      hit_q       <= 1'b0;
      dirty_q     <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      req_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      rsp_valid_q <= rsp_valid_d;
      if (req_hs) begin
        addr_q  <= req_addr_i[ADDR_W-1:OFFSET_W];
        write_q <= req_write_i;
        data_q  <= req_wdata_i;
        hit_q   <= 1'b0;
        dirty_q <= 1'b0;
      end
      // Lookup result capture and statistics share the R handshake
      if (r_hs) begin
        data_q  <= rdata_i[DATA_W-1:0];
        hit_q   <= tag_hit;
        dirty_q <= rdata_i[D_BIT];
        if (tag_hit) hit_cnt_q <= hit_cnt_q + 32'd1;
        else         miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign req_ready_o = req_ready_q;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = rready_q;
  assign awvalid_o   = awvalid_q;
  assign wvalid_o    = wvalid_q;
  assign bready_o    = bready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_write_o = write_q;
  assign rsp_hit_o   = hit_q;
  assign rsp_dirty_o = dirty_q;
  assign rsp_data_o  = data_q;
  assign wdata_o     = data_q;
  assign araddr_o    = {addr_q, OFFSET_W'(0)};
  assign awaddr_o    = {addr_q, OFFSET_W'(0)};
  assign arid_o      = ID_W'(ID);
  assign awid_o      = ID_W'(ID);
  assign wid_o       = ID_W'(ID);
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

  // Single outstanding transaction: response IDs and line-offset bits carry no information
  logic unused_bits;
  assign unused_bits = ^{rid_i, bid_i, rdata_i[TF_LO-1:DATA_W], req_addr_i[OFFSET_W-1:0]};

endmodule

// File: tb/tb_dc_tag_checker.sv
// Directed bench for dc_tag_checker: a hand-driven AXI slave and requester.
module tb_dc_tag_checker;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_write;
  logic [63:0]  req_addr;
  logic [511:0] req_wdata;
  logic         rsp_valid, rsp_ready, rsp_write, rsp_hit, rsp_dirty;
  logic [511:0] rsp_data;
  logic [15:0]  arid, rid, awid, wid, bid;
  logic [63:0]  araddr, awaddr;
  logic         arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [575:0] rdata;
  logic [511:0] wdata;
  logic [31:0]  hit_cnt, miss_cnt;

  int vectors = 0;
  int miscompares = 0;
  int aw_n = 0, w_n = 0, b_n = 0;
  logic [31:0] exp_h, exp_m;

  dc_tag_checker dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
    .rsp_hit_o(rsp_hit), .rsp_dirty_o(rsp_dirty), .rsp_data_o(rsp_data),
    .arid_o(arid), .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .rid_i(rid), .rdata_i(rdata), .rvalid_i(rvalid), .rready_o(rready),
    .awid_o(awid), .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
    .wid_o(wid), .wdata_o(wdata), .wvalid_o(wvalid), .wready_i(wready),
    .bid_i(bid), .bvalid_i(bvalid), .bready_o(bready),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  // Beat counters seen by the slave
  always @(posedge clk) begin
    if (awvalid && awready) aw_n <= aw_n + 1;
    if (wvalid && wready)   w_n  <= w_n + 1;
    if (bvalid && bready)   b_n  <= b_n + 1;
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return req_ready;
      1:       return arvalid;
      2:       return rready;
      3:       return awvalid;
      4:       return bready;
      default: return rsp_valid;
    endcase
  endfunction

  // Tag word: valid, dirty, 32-bit tag field, 30 spare bits
  function automatic logic [63:0] tw(input logic v, input logic d, input logic [31:0] tf);
    return {v, d, tf, 30'h0};
  endfunction

  task automatic wait_hi(input int s, input string tag);
    int n = 0;
    while (sig(s) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_b(tag, sig(s), 1'b1);
  endtask

  task automatic send_req(input logic w, input logic [63:0] a, input logic [511:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    wait_hi(0, "req_ready");
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic fill(input logic [63:0] a, input logic [511:0] d, input bit staggered);
    int aw0 = aw_n, w0 = w_n, b0 = b_n;
    send_req(1'b1, a, d);
    chk_b("fill awvalid", awvalid, 1'b1);
    chk_b("fill wvalid", wvalid, 1'b1);
    chk_64("fill awaddr", awaddr, {a[63:6], 6'b0});
    chk_d("fill wdata", wdata, d);
    chk_32("fill awid", 32'(awid), 32'd1);
    chk_b("fill req_ready low", req_ready, 1'b0);
    if (!staggered) begin
      awready = 1'b1; wready = 1'b1;
      @(negedge clk);
      awready = 1'b0; wready = 1'b0;
    end else begin
      awready = 1'b1;
      @(negedge clk);
      awready = 1'b0;
      chk_b("stagger aw drop", awvalid, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk_b("stagger w held", wvalid, 1'b1);
      chk_d("stagger wdata held", wdata, d);
      wready = 1'b1;
      @(negedge clk);
      wready = 1'b0;
    end
    chk_b("awvalid done", awvalid, 1'b0);
    chk_b("wvalid done", wvalid, 1'b0);
    wait_hi(4, "bready");
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    chk_b("bready after B", bready, 1'b0);
    wait_hi(5, "fill rsp_valid");
    chk_b("fill rsp_write", rsp_write, 1'b1);
    chk_b("fill rsp_hit", rsp_hit, 1'b0);
    chk_b("fill rsp_dirty", rsp_dirty, 1'b0);
    chk_d("fill rsp_data", rsp_data, d);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk_b("fill rsp done", rsp_valid, 1'b0);
    chk_b("fill back idle", req_ready, 1'b1);
    chk_32("aw beats", 32'(aw_n - aw0), 32'd1);
    chk_32("w beats", 32'(w_n - w0), 32'd1);
    chk_32("b beats", 32'(b_n - b0), 32'd1);
  endtask

  task automatic lookup(input logic [63:0] a, input logic [63:0] tag_word, input logic [511:0] ld,
                        input logic exp_hit, input logic exp_dirty, input int delay);
    send_req(1'b0, a, {8{64'hDEAD_BEEF_0BAD_F00D}});
    chk_b("ar valid", arvalid, 1'b1);
    chk_64("araddr", araddr, {a[63:6], 6'b0});
    chk_32("arid", 32'(arid), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk_b("ar held", arvalid, 1'b1);
    chk_64("araddr held", araddr, {a[63:6], 6'b0});
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk_b("ar done", arvalid, 1'b0);
    chk_b("rready in R", rready, 1'b1);
    rvalid = 1'b1;
    rdata  = {tag_word, ld};
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = '1;
    if (exp_hit) exp_h = exp_h + 32'd1;
    else         exp_m = exp_m + 32'd1;
    chk_b("rready after R", rready, 1'b0);
    chk_b("lookup rsp_valid", rsp_valid, 1'b1);
    chk_b("lookup rsp_write", rsp_write, 1'b0);
    chk_b("lookup rsp_hit", rsp_hit, exp_hit);
    chk_b("lookup rsp_dirty", rsp_dirty, exp_dirty);
    chk_d("lookup rsp_data", rsp_data, ld);
    chk_32("hit_cnt", hit_cnt, exp_h);
    chk_32("miss_cnt", miss_cnt, exp_m);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk_b("stall rsp_valid", rsp_valid, 1'b1);
      chk_b("stall rsp_hit", rsp_hit, exp_hit);
      chk_d("stall rsp_data", rsp_data, ld);
      chk_b("stall req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk_b("lookup rsp done", rsp_valid, 1'b0);
    chk_b("lookup back idle", req_ready, 1'b1);
  endtask

  localparam logic [63:0] ADDR_A = 64'h0000_0001_0000_0040;
  localparam logic [63:0] ADDR_B = 64'h0000_0002_0000_0040;
  localparam logic [63:0] ADDR_C = 64'h0000_1234_5678_9AC5;

  initial begin
    logic [511:0] a5, dc;
    a5 = {64{8'hA5}};
    dc = {16{32'h1357_9BDF}};
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rid = 16'h7;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 16'h9;
    exp_h = '0; exp_m = '0;

    repeat (3) @(negedge clk);
    chk_b("rst req_ready", req_ready, 1'b0);
    chk_b("rst arvalid", arvalid, 1'b0);
    chk_b("rst rready", rready, 1'b0);
    chk_b("rst awvalid", awvalid, 1'b0);
    chk_b("rst wvalid", wvalid, 1'b0);
    chk_b("rst bready", bready, 1'b0);
    chk_b("rst rsp_valid", rsp_valid, 1'b0);
    chk_32("rst hit_cnt", hit_cnt, 32'd0);
    chk_32("rst miss_cnt", miss_cnt, 32'd0);
    chk_d("rst rsp_data", rsp_data, '0);
    rst = 1'b0;
    @(negedge clk);
    chk_b("post-rst req_ready", req_ready, 1'b1);

    // Fill then hit on the same line; then a different tag on the same index misses
    fill(ADDR_A, a5, 1'b0);
    lookup(ADDR_A, tw(1'b1, 1'b0, 32'h0000_0001), a5, 1'b1, 1'b0, 0);
    lookup(ADDR_B, tw(1'b1, 1'b1, 32'h0000_0001), a5, 1'b0, 1'b1, 5);

    // Staggered AW/W acceptance, then dirty hit and invalid-line miss
    fill(ADDR_C, dc, 1'b1);
    lookup(ADDR_C, tw(1'b1, 1'b1, 32'h0000_1234), dc, 1'b1, 1'b1, 1);
    lookup(ADDR_C, tw(1'b0, 1'b0, 32'h0000_1234), ~dc, 1'b0, 1'b0, 0);

    // Reset while waiting on R abandons the lookup
    send_req(1'b0, ADDR_A, '0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk_b("pre-rst rready", rready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_b("mid-rst rready", rready, 1'b0);
    chk_b("mid-rst rsp_valid", rsp_valid, 1'b0);
    chk_b("mid-rst arvalid", arvalid, 1'b0);
    chk_32("mid-rst hit_cnt", hit_cnt, 32'd0);
    chk_32("mid-rst miss_cnt", miss_cnt, 32'd0);
    chk_d("mid-rst rsp_data", rsp_data, '0);
    rst = 1'b0;
    exp_h = '0; exp_m = '0;
    @(negedge clk);
    chk_b("after mid-rst req_ready", req_ready, 1'b1);
    lookup(ADDR_A, tw(1'b1, 1'b0, 32'h0000_0001), a5, 1'b1, 1'b0, 0);

    // Miss counter wrap from all-ones
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.miss_cnt_q;
    chk_32("preset miss_cnt", miss_cnt, 32'hFFFF_FFFF);
    exp_m = 32'hFFFF_FFFF;
    lookup(ADDR_B, tw(1'b1, 1'b0, 32'h0000_0001), a5, 1'b0, 1'b0, 0);
    chk_32("wrapped miss_cnt", miss_cnt, 32'd0);
    chk_32("hit_cnt after wrap", hit_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
